// File: rtl/logicnet_pkg.sv
// logicnet_pkg: shared state type and slice/address helpers for the LogicNets LUT layer
package logicnet_pkg;

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} lut_state_e;

    function automatic int addr_w(input int depth);
        return depth <= 2 ? 1 : $clog2(depth);
    endfunction

    function automatic int in_off(input int n, input int in_w);
        return n * in_w;
    endfunction

    function automatic int out_off(input int n, input int out_w);
        return n * out_w;
    endfunction

endpackage

// File: rtl/logicnet_lut_layer_pipe_if.sv
// logicnet_lut_layer_pipe_if: input vector and result stream handshakes of the LUT layer
interface logicnet_lut_layer_pipe_if #(
    parameter int N_NEURONS = 8,
    parameter int IN_W      = 6,
    parameter int OUT_W     = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [N_NEURONS*IN_W-1:0]  in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [N_NEURONS*OUT_W-1:0] out_data;

    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
    modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/logicnet_lut_ram.sv
// logicnet_lut_ram: distributed truth-table RAM, synchronous write, asynchronous read
module logicnet_lut_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int W     = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    (* ram_style = "distributed", rom_style = "distributed" *) logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/logicnet_lut_layer_pipe.sv
// logicnet_lut_layer_pipe: loadable per-neuron LUT layer with registered valid/ready output
// LUT_PARITY_EN adds a parity RAM and the sticky par_err check.
module logicnet_lut_layer_pipe
    import logicnet_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int IN_W      = 6,
    parameter int OUT_W     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_start,
    input  logic                       cfg_valid,
    input  logic [N_NEURONS*OUT_W-1:0] cfg_data,
    input  logic                       cfg_par,
    output logic                       load_done,
    output logic                       tbl_ready,
    output logic                       par_err,
    logicnet_lut_layer_pipe_if.slave   bus
);
    localparam int DEPTH = 2 ** IN_W;
    localparam int AW    = addr_w(DEPTH);

    lut_state_e                 state;
    logic [AW-1:0]              addr_cnt;
    logic [N_NEURONS*OUT_W-1:0] lookup, out_data;
    logic                       out_valid, we, accept;

    // a start beat never writes; it only restarts the count
    assign we            = state == LOAD && cfg_valid && !cfg_start && !rst;
    assign tbl_ready     = state == RUN;
    assign bus.in_ready  = tbl_ready && (!out_valid || bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_n
        logicnet_lut_ram #(.DEPTH(DEPTH), .AW(AW), .W(OUT_W)) u_ram (
            .clk,
            .we,
            .waddr(addr_cnt),
            .wdata(cfg_data[out_off(i, OUT_W) +: OUT_W]),
            .raddr(bus.in_data[in_off(i, IN_W) +: IN_W]),
            .rdata(lookup[out_off(i, OUT_W) +: OUT_W])
        );
    end

    always_ff @(posedge clk)
        if (rst) begin
            state     <= EMPTY;
            addr_cnt  <= '0;
            load_done <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            load_done <= 1'b0;
            if (cfg_start) begin
                state    <= LOAD;
                addr_cnt <= '0;
            end else if (we) begin
                addr_cnt <= addr_cnt + 1'b1;
                if (&addr_cnt) begin
                    state     <= RUN;
                    load_done <= 1'b1;
                end
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= lookup;
            end else if (bus.out_ready) out_valid <= 1'b0;
        end

`ifdef LUT_PARITY_EN
    logic par_rd;

    logicnet_lut_ram #(.DEPTH(DEPTH), .AW(AW), .W(1)) u_par (
        .clk,
        .we,
        .waddr(addr_cnt),
        .wdata(cfg_par),
        .raddr(bus.in_data[IN_W-1:0]),
        .rdata(par_rd)
    );

    // registered on accept so the flag rises together with out_valid
    always_ff @(posedge clk)
        if (rst || cfg_start) par_err <= 1'b0;
        else if (accept && ((^lookup) != par_rd)) par_err <= 1'b1;
`else
    assign par_err = 1'b0 & cfg_par;
`endif
endmodule

// File: tb/tb_logicnet_lut_layer_pipe.sv
// tb_logicnet_lut_layer_pipe: random stimulus against a table/queue reference model
module tb_logicnet_lut_layer_pipe;
    localparam int N  = 8;
    localparam int IW = 6;
    localparam int OW = 2;
    localparam int D  = 2 ** IW;

    logic            clk = 1'b0;
    logic            rst, cfg_start, cfg_valid, cfg_par;
    logic [N*OW-1:0] cfg_data;
    logic            load_done, tbl_ready, par_err;

    logicnet_lut_layer_pipe_if #(.N_NEURONS(N), .IN_W(IW), .OUT_W(OW)) bus ();

    logicnet_lut_layer_pipe #(.N_NEURONS(N), .IN_W(IW), .OUT_W(OW)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_data(cfg_data),
        .cfg_par(cfg_par),
        .load_done(load_done),
        .tbl_ready(tbl_ready),
        .par_err(par_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, n_acc = 0;

    // reference model: table contents, download progress, pending results
    logic [N*OW-1:0] tbl [D];
    logic            ptbl [D];
    int              m_mode = 0;
    int              m_cnt = 0;
    bit              m_ld = 0, m_pe = 0;
    logic [N*OW-1:0] q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*OW-1:0] ref_lookup(input logic [N*IW-1:0] a);
        logic [N*OW-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            logic [N*OW-1:0] w = tbl[a[i*IW +: IW]];
            r[i*OW +: OW] = w[i*OW +: OW];
        end
        return r;
    endfunction

    task automatic cyc();
        bit              rdy, pe_en;
        logic [N*OW-1:0] lk;
        #1;
        rdy = m_mode == 2 && (q.size() == 0 || bus.out_ready);
        chk("in_ready", 64'(bus.in_ready), 64'(rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 64'(bus.out_data), 64'(q[0]));
        chk("load_done", 64'(load_done), 64'(m_ld));
        chk("tbl_ready", 64'(tbl_ready), 64'(m_mode == 2));
        chk("par_err", 64'(par_err), 64'(m_pe));
`ifdef LUT_PARITY_EN
        pe_en = 1;
`else
        pe_en = 0;
`endif
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_ld = 0; m_pe = 0;
            q.delete();
        end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && rdy) begin
                lk = ref_lookup(bus.in_data);
                q.push_back(lk);
                n_acc++;
                if (pe_en && ((^lk) != ptbl[bus.in_data[IW-1:0]])) m_pe = 1;
            end
            m_ld = 0;
            if (cfg_start) begin
                m_mode = 1; m_cnt = 0; m_pe = 0;
            end else if (m_mode == 1 && cfg_valid) begin
                tbl[m_cnt]  = cfg_data;
                ptbl[m_cnt] = cfg_par;
                if (m_cnt == D - 1) begin
                    m_mode = 2; m_ld = 1; m_cnt = 0;
                end else m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // mode 0: entry = a[1:0] in every neuron, 1: all ones, 2: random; bad marks a wrong-parity address
    task automatic load(input int mode, input int beats, input int bad);
        int a = 0;
        cfg_start = 1; cfg_valid = 1; cfg_data = '1; cfg_par = 0;
        cyc();
        cfg_start = 0;
        while (a < beats) begin
            cfg_valid = $urandom_range(0, 4) != 0;
            cfg_data  = mode == 0 ? {N{a[1:0]}} : mode == 1 ? '1 : (N*OW)'($urandom);
            cfg_par   = (^cfg_data) ^ (a == bad);
            cyc();
            if (cfg_valid) a++;
        end
        cfg_valid = 0;
        if (beats == D) begin
            cyc();
            chk("tbl_ready_after_load", 64'(tbl_ready), 64'd1);
        end
    endtask

    task automatic lookup_one(input logic [N*IW-1:0] a, input logic [N*OW-1:0] exp, input string tag);
        bus.in_valid = 1; bus.in_data = a; bus.out_ready = 1;
        cyc();
        bus.in_valid = 0;
        #1;
        chk(tag, 64'(bus.out_data), 64'(exp));
        cyc();
    endtask

    task automatic stream(input int n, input int maxc);
        int start = n_acc;
        for (int c = 0; c < maxc && n_acc - start < n; c++) begin
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.in_data   = (N*IW)'({$urandom, $urandom});
            bus.out_ready = $urandom_range(0, 1) != 0;
            cyc();
        end
        chk("stream_count", 64'(n_acc - start), 64'(n));
        bus.in_valid = 0; bus.out_ready = 1;
        repeat (3) cyc();
    endtask

    initial begin
        rst = 1; cfg_start = 0; cfg_valid = 0; cfg_data = '0; cfg_par = 0;
        bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
        @(negedge clk);
        cyc(); cyc();
        rst = 0;
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        bus.in_valid = 1; cfg_valid = 1;
        repeat (5) cyc();
        bus.in_valid = 0; cfg_valid = 0;

        load(0, D, -1);
        lookup_one({N{6'h2D}}, {N{2'b01}}, "lookup_2d");

        load(2, D, -1);
        stream(100, 2000);

        bus.in_valid = 1; bus.in_data = (N*IW)'({$urandom, $urandom}); bus.out_ready = 0;
        cyc();
        bus.in_valid = 0;
        load(0, 31, -1);
        bus.out_ready = 1;
        load(1, D, -1);
        lookup_one((N*IW)'({$urandom, $urandom}), '1, "reload_ones");
        stream(20, 400);

        load(2, 11, -1);
        rst = 1; cfg_valid = 1;
        cyc();
        rst = 0; cfg_valid = 0;
        bus.in_valid = 1;
        cyc();
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 0;
        load(2, D, -1);
        stream(20, 400);

        load(2, D, 5);
        lookup_one({N{6'd5}}, ref_lookup({N{6'd5}}), "par_lookup");
`ifdef LUT_PARITY_EN
        chk("par_err_set", 64'(par_err), 64'd1);
`else
        chk("par_err_off", 64'(par_err), 64'd0);
`endif
        cfg_start = 1;
        cyc();
        cfg_start = 0;
        chk("par_err_cleared", 64'(par_err), 64'd0);
        cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/logicnet_lut_layer_pipe.md
Name: logicnet_lut_layer_pipe

Overview:
Parametrised, pipelined successor to the fixed combinational per-neuron truth-table ROMs. It implements a layer of N_NEURONS LogicNets neurons. Each neuron has its own IN_W-bit address and OUT_W-bit result, held in a runtime-loadable distributed-RAM truth table.
- Adds table download, a registered output with valid/ready flow control, and load/run sequencing.
- Sits between adjacent layer stages in the classifier datapath. Fan-in wiring is done outside the block.

Parameters:
N_NEURONS, 8, number of neurons in the layer
IN_W, 6, address bits per neuron (fan-in × input bits); DEPTH = 2**IN_W entries (localparam)
OUT_W, 2, result bits per neuron

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
cfg_start  input  1  pulse: begin a table download (restart if one is in progress)
cfg_valid  input  1  download beat valid
cfg_data  input  N_NEURONS*OUT_W  one entry per neuron for the current address; neuron i at [i*OUT_W +: OUT_W]
cfg_par  input  1  even parity over cfg_data (used only with LUT_PARITY_EN)
load_done  output  1  one-cycle pulse after the last beat is written
tbl_ready  output  1  high in RUN
in_valid  input  1  input vector valid
in_ready  output  1  block accepts input
in_data  input  N_NEURONS*IN_W  per-neuron addresses; neuron i at [i*IN_W +: IN_W]
out_valid  output  1  result valid
out_ready  input  1  downstream accepts
out_data  output  N_NEURONS*OUT_W  per-neuron results
par_err  output  1  sticky table parity error

Behaviour:
- FSM states: EMPTY, LOAD, RUN.
  - Reset → EMPTY.
  - cfg_start in any state → LOAD with addr_cnt = 0.
  - In LOAD, each cycle with cfg_valid writes cfg_data to all neuron RAMs at addr_cnt, then addr_cnt increments.
  - Beat at addr_cnt = DEPTH-1 → RUN next cycle, load_done pulses for 1 cycle, addr_cnt wraps to 0.
- cfg_valid in EMPTY or RUN is ignored.
- cfg_start together with cfg_valid: start wins, the beat is dropped, and the count restarts at 0.
- Reset does not clear RAM contents. A new download is required after reset.
- Reset values: out_valid=0, out_data=0, load_done=0, tbl_ready=0, in_ready=0, par_err=0, addr_cnt=0.
- in_ready = (state==RUN) && (!out_valid || out_ready).
- Accept on in_valid && in_ready. The following cycle out_valid=1 and out_data = registered lookups of all neurons. Latency is 1 cycle; throughput is 1 vector per cycle under continuous out_ready.
- out_valid && !out_ready: out_data and out_valid are held stable and no new input is accepted.
- Consume without new accept: out_valid → 0.
- cfg_start while out_valid=1: the pending result is held until consumed. Its data came from the old table. No accepts occur until RUN.
- Reset mid-load or mid-transfer: pending output is discarded and the block returns to EMPTY.
- All neurons share cfg addressing. The read ports are independent per neuron.

Optional Feature:
LUT_PARITY_EN
- Defined:
  - Each RAM word stores cfg_par alongside the entry.
  - On every accepted lookup, neuron 0's stored parity is compared against the XOR of all neuron results read at their addresses. Stored parity covers the full cfg_data word, so the check is performed on a parallel parity RAM read at neuron 0's address, alongside the full word.
  - A mismatch sets par_err on the cycle out_valid rises. par_err is sticky; it clears on rst or cfg_start.
- Undefined: no parity storage, cfg_par is ignored, par_err is tied to 0.

Decomposition:
- Package logicnet_pkg holds:
  - lut_state_e enum (EMPTY, LOAD, RUN)
  - clog2-based address width helper
  - per-neuron slice-offset functions
- One sub-module, logicnet_lut_ram: DEPTH×OUT_W distributed RAM with 1 synchronous write port and 1 asynchronous read port, rom_style/ram_style "distributed". It is instantiated N_NEURONS times (plus one parity RAM under the macro).
- Top level holds the FSM, counter and output register.

Test Plan:
1. Reset, then in_valid=1 held → in_ready=0, out_valid=0, tbl_ready=0 throughout EMPTY.
2. Download 64 beats, entry[a] = {N_NEURONS{a[1:0]}} → load_done pulses once on the cycle after beat 63, tbl_ready=1. Then in_data = {8{6'h2D}} → out_data = {8{2'b01}} one cycle later.
3. Stream 100 random vectors with out_ready toggling 50% → results match the scoreboard, no drop or duplicate, out_data stable while stalled.
4. cfg_start after beat 30, then a full 64-beat reload with entry=2'b11 → every lookup returns 2'b11, with no residue of the first table.
5. rst asserted mid-download at beat 10 → EMPTY, in_ready=0. A full reload restores correct RUN behaviour.
6. LUT_PARITY_EN: load address 5 with a wrong cfg_par, look up address 5 → par_err=1 with out_valid and stays high. A following cfg_start clears it. Without the macro, par_err stays 0.
